// File: rtl/sseg_scan_capture.sv
// sseg_scan_capture: recovers the four digits shown on a multiplexed,
// active-low 7-segment display by watching its anode and segment lines.
// A digit is accepted once {an, sseg} has been stable for STABLE_CYCLES
// synchronized samples with exactly one anode low; accepted raw patterns
// are held per digit and decoded to hex.
// Optional feature macro: SSEG_CAPTURE_TIMEOUT_EN (scan-activity timeout).
`default_nettype none

module sseg_scan_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT_BITS  = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] an,
  input  logic [6:0] sseg,
  output logic [6:0] digit0,
  output logic [6:0] digit1,
  output logic [6:0] digit2,
  output logic [6:0] digit3,
  output logic [3:0] code0,
  output logic [3:0] code1,
  output logic [3:0] code2,
  output logic [3:0] code3,
  output logic [3:0] known,
  output logic       frame_done,
  output logic       scan_active,
  output logic       scan_error
);

  localparam int               CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [3:0]       AN_IDLE = 4'b1111;
  localparam logic [6:0]       SEG_OFF = 7'b1111111;

  if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255 || TIMEOUT_BITS < 2) begin : g_bad_param
    $error("sseg_scan_capture: STABLE_CYCLES must be 2..255, TIMEOUT_BITS >= 2");
  end

  // Segment pattern to {known, hex}; unmatched patterns give {0, 0}.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'b1000000: r = 5'h10;
      7'b1111001: r = 5'h11;
      7'b0100100: r = 5'h12;
      7'b0110000: r = 5'h13;
      7'b0011001: r = 5'h14;
      7'b0010010: r = 5'h15;
      7'b0000010: r = 5'h16;
      7'b1111000: r = 5'h17;
      7'b0000000: r = 5'h18;
      7'b0010000: r = 5'h19;
      7'b0001000: r = 5'h1A;
      7'b0000011: r = 5'h1B;
      7'b1000110: r = 5'h1C;
      7'b0100001: r = 5'h1D;
      7'b0000110: r = 5'h1E;
      7'b0001110: r = 5'h1F;
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  // Number of selected (low) anode lines.
  function automatic logic [2:0] an_low_count(input logic [3:0] a);
    return 3'(!a[0]) + 3'(!a[1]) + 3'(!a[2]) + 3'(!a[3]);
  endfunction

  // p0/p1: two-flop synchronizer; p2: previous synchronized sample.
  // Synchronizers clear to the idle/blank pattern so reset never looks
  // like a stable multi-digit selection.
  logic [3:0]       an_p0, an_p1, an_p2;
  logic [6:0]       sseg_p0, sseg_p1, sseg_p2;
  logic [CNT_W-1:0] stab_cnt;
  logic [CNT_W-1:0] stab_cnt_nxt;
  logic             settle;
  logic [3:0]       sel;
  logic             acc_vld;
  logic             err_vld;
  logic [3:0]       acc_mask;
  logic [3:0]       mask;
  logic [3:0]       mask_nxt;
  logic [6:0]       digit_q [4];

  // Synchronize inputs and keep the previous sample for change detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_p0   <= AN_IDLE;
      an_p1   <= AN_IDLE;
      an_p2   <= AN_IDLE;
      sseg_p0 <= SEG_OFF;
      sseg_p1 <= SEG_OFF;
      sseg_p2 <= SEG_OFF;
    end else begin
      an_p0   <= an;
      an_p1   <= an_p0;
      an_p2   <= an_p1;
      sseg_p0 <= sseg;
      sseg_p1 <= sseg_p0;
      sseg_p2 <= sseg_p1;
    end
  end

  // Stability counting and classification of a freshly settled pattern.
  always_comb begin
    stab_cnt_nxt = CNT_ONE;
    if ({an_p1, sseg_p1} == {an_p2, sseg_p2})
      stab_cnt_nxt = (stab_cnt == CNT_MAX) ? CNT_MAX : stab_cnt + CNT_ONE;
    // Fires only on the transition into saturation: one event per dwell.
    settle   = (stab_cnt_nxt == CNT_MAX) && (stab_cnt != CNT_MAX);
    sel      = ~an_p1;
    acc_vld  = settle && (an_low_count(an_p1) == 3'd1);
    err_vld  = settle && (an_low_count(an_p1) >= 3'd2);
    acc_mask = acc_vld ? sel : 4'b0000;
    // A full mask is consumed by the frame_done pulse; an accept in that
    // same cycle starts the next frame.
    mask_nxt = (mask == 4'b1111) ? acc_mask : (mask | acc_mask);
  end

  // Stability counter, saturating at STABLE_CYCLES.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stab_cnt <= '0;
    else       stab_cnt <= stab_cnt_nxt;
  end

  // Per-digit raw pattern registers, loaded on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) digit_q[k] <= SEG_OFF;
    end else begin
      for (int k = 0; k < 4; k++)
        if (acc_mask[k]) digit_q[k] <= sseg_p1;
    end
  end

`ifdef SSEG_CAPTURE_TIMEOUT_EN
  localparam logic [TIMEOUT_BITS-1:0] TO_MAX = '1;
  logic [TIMEOUT_BITS-1:0] to_cnt;

  // Frame mask, event pulses and scan activity with inactivity timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask        <= 4'b0000;
      frame_done  <= 1'b0;
      scan_error  <= 1'b0;
      scan_active <= 1'b0;
      to_cnt      <= '0;
    end else begin
      frame_done <= (mask == 4'b1111);
      scan_error <= err_vld;
      mask       <= mask_nxt;
      if (acc_vld) begin
        to_cnt      <= '0;
        scan_active <= 1'b1;
      end else if (to_cnt != TO_MAX) begin
        to_cnt <= to_cnt + TIMEOUT_BITS'(1);
        // Counter reaches all-ones on this edge: scanning has stopped.
        if (to_cnt == TO_MAX - TIMEOUT_BITS'(1)) begin
          scan_active <= 1'b0;
          mask        <= 4'b0000;
        end
      end
    end
  end
`else
  // Frame mask, event pulses and sticky scan activity.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask        <= 4'b0000;
      frame_done  <= 1'b0;
      scan_error  <= 1'b0;
      scan_active <= 1'b0;
    end else begin
      frame_done <= (mask == 4'b1111);
      scan_error <= err_vld;
      mask       <= mask_nxt;
      if (acc_vld) scan_active <= 1'b1;
    end
  end
`endif

  assign digit0 = digit_q[0];
  assign digit1 = digit_q[1];
  assign digit2 = digit_q[2];
  assign digit3 = digit_q[3];

  // Decoded view follows the digit registers combinationally.
  always_comb begin
    logic [4:0] d0, d1, d2, d3;
    d0 = seg_decode(digit_q[0]);
    d1 = seg_decode(digit_q[1]);
    d2 = seg_decode(digit_q[2]);
    d3 = seg_decode(digit_q[3]);
    code0 = d0[3:0];
    code1 = d1[3:0];
    code2 = d2[3:0];
    code3 = d3[3:0];
    known = {d3[4], d2[4], d1[4], d0[4]};
  end

endmodule

`default_nettype wire
